sqrt_bcd_formatter: RTL
=======================

Name: sqrt_bcd_formatter

Overview:
- Downstream consumer of the combinational square-root stage.
- Takes its unsigned 16-bit fixed-point result (8 integer bits, 8 fraction bits, i.e. value/256) and converts it into four BCD digits in the form II.FF: two integer digits and two hundredths digits.
- Feeds the display/readout logic of the baggage-drop datapath.
- Iterative double-dabble conversion behind a valid/ready handshake.

Parameters:
- IN_W, 16, input word width; only 16 is supported and verified.
- FRAC_W, 8, number of fraction bits in in_data; only 8 is supported and verified.
- BIN_W, 14, width of the scaled binary value (holds 0..10000); equals the number of SHIFT iterations.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept a new word (high only in IDLE)
- in_data  in  16  square-root result; [15:8] integer part, [7:0] fraction
- out_valid  out  1  out_bcd and out_ovf are valid
- out_ready  in  1  consumer accepts the output
- out_bcd  out  16  {tens, units, tenths, hundredths}, 4 bits per digit
- out_ovf  out  1  value saturated to 99.99

Behaviour:
- Reset: clk and rst_n are the only clock and reset; reset is asynchronous, active-low.
  - While rst_n is low: state=IDLE, in_ready=0, out_valid=0, out_bcd=16'h0000, out_ovf=0, all internal registers cleared.
  - in_ready rises on the first clock edge after rst_n deasserts.
- States: IDLE, SCALE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture in_data and go to SCALE. in_ready drops at that edge.
- SCALE (1 cycle):
  - int = in_data[15:8].
  - hund = (in_data[7:0]*100) >> 8, truncated, using a 15-bit product.
  - value = int*100 + hund.
  - If int > 99 or value > 9999: value = 9999 and ovf_r = 1; otherwise ovf_r = 0.
  - Clear the BCD shift register and set iteration count = 0. Go to SHIFT.
- SHIFT (BIN_W = 14 cycles):
  - Each cycle, add 3 to every BCD nibble that is >= 5, then shift {bcd, value} left by 1 bit. Both steps happen in the same cycle.
  - After the 14th shift, go to DONE.
- DONE:
  - out_valid=1; out_bcd and out_ovf are stable.
  - On an edge with out_ready=1, go to IDLE; out_valid drops at that edge.
  - out_bcd and out_ovf keep their last value until the next DONE.
- Latency: out_valid rises exactly 15 clock edges after the accept edge. If out_ready is held at 1, back-to-back throughput is one word per 17 cycles.
- Handshake rules:
  - in_data is sampled only on the accept edge; changes to in_data during conversion are ignored.
  - in_valid outside IDLE is ignored, with no queueing.
  - out_ready outside DONE is ignored.
  - There is no accept-while-output-pending path.
- Reset mid-operation: any state returns to IDLE immediately, the in-flight conversion is discarded, and out_valid goes low asynchronously.
- Boundary values:
  - in_data=0 gives 0000.
  - The maximum upstream value 0x0FF7 gives 1596.
  - Integer part 99 with a large fraction stays within 99.99, since truncation never reaches 100.
  - Integer part >= 100 saturates to 9999 with ovf.

Optional Feature:
- Macro: SQRT_BCD_ROUND_EN.
- Defined: hund = (in_data[7:0]*100 + 128) >> 8, i.e. round to nearest with ties going up. The result can reach 100, which carries into the integer part. value > 9999 after rounding saturates to 9999 with ovf=1; example: 0x63FF gives 9999, ovf=1.
- Undefined: truncation as described in Behaviour; hund never exceeds 99.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset mid-SHIFT: pulse rst_n low for 1 cycle while in SHIFT -> out_valid=0 immediately, state IDLE, in_ready=1 one edge after release, no stale out_valid.
- in_data=0x016A (1.414) -> out_bcd=16'h0141, out_ovf=0, out_valid exactly 15 edges after accept.
- in_data=0x0FF7 -> out_bcd=16'h1596 (truncate) or 16'h1596 (round: 24700+128>>8=96); out_ovf=0.
- in_data=0x03FF -> without SQRT_BCD_ROUND_EN: 16'h0399; with it: 16'h0400 (carry into integer part).
- in_data=0x6400 (int 100) -> out_bcd=16'h9999, out_ovf=1. Then in_data=0x0480 -> 16'h0450, out_ovf=0 (flag clears).
- Hold out_ready=0 for 20 cycles in DONE while toggling in_valid and in_data -> out_valid stays high, out_bcd unchanged, in_ready=0. Raising out_ready returns to IDLE and the next word is accepted normally.

Source files
------------

// File: rtl/sqrt_bcd_formatter.sv
// Fixed-point (8.8) to four-digit BCD II.FF converter, iterative double-dabble.
// Optional SQRT_BCD_ROUND_EN: round the hundredths digit to nearest instead of truncating.
module sqrt_bcd_formatter #(
    parameter int IN_W   = 16,
    parameter int FRAC_W = 8,
    parameter int BIN_W  = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_bcd,
    output logic            out_ovf
);

`ifdef SQRT_BCD_ROUND_EN
    localparam logic [14:0] RND = 15'd128;
`else
    localparam logic [14:0] RND = 15'd0;
`endif

    typedef enum logic [1:0] {IDLE, SCALE, SHIFT, DONE} state_t;

    state_t state, state_n;

    logic [IN_W-1:0]  data_r;
    logic [BIN_W-1:0] value_r;
    logic [15:0]      bcd_r;
    logic [3:0]       cnt_r;
    logic             ovf_r;
    logic             ready_r;

    logic [IN_W-FRAC_W-1:0] int_part;
    logic [14:0]            prod;
    logic [15:0]            value_w;
    logic                   sat;
    logic [15:0]            adj;
    logic [15:0]            shift_w;
    logic                   last;
    logic                   accept;

    assign int_part = data_r[IN_W-1:FRAC_W];
    assign prod     = {7'd0, data_r[FRAC_W-1:0]} * 15'd100 + RND;
    assign value_w  = {8'd0, int_part} * 16'd100 + 16'(prod >> 8);
    assign sat      = (int_part > 8'd99) || (value_w > 16'd9999);

    // Double-dabble correction: any digit >= 5 would overflow past 9 on the shift.
    always_comb begin
        adj = bcd_r;
        for (int i = 0; i < 4; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
        end
    end

    assign shift_w = {adj[14:0], value_r[BIN_W-1]};
    assign last    = (cnt_r == 4'(BIN_W - 1));
    assign accept  = in_valid && ready_r;

    assign in_ready  = ready_r;
    assign out_valid = (state == DONE);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (accept)    state_n = SCALE;
            SCALE:                state_n = SHIFT;
            SHIFT: if (last)      state_n = DONE;
            DONE:  if (out_ready) state_n = IDLE;
            default:              state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready_r <= 1'b0;
        end else begin
            state   <= state_n;
            ready_r <= (state_n == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= '0;
            value_r <= '0;
            bcd_r   <= '0;
            cnt_r   <= '0;
            ovf_r   <= 1'b0;
            out_bcd <= '0;
            out_ovf <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept)
                        data_r <= in_data;
                end
                SCALE: begin
                    value_r <= sat ? BIN_W'(9999) : value_w[BIN_W-1:0];
                    ovf_r   <= sat;
                    bcd_r   <= '0;
                    cnt_r   <= '0;
                end
                SHIFT: begin
                    bcd_r   <= shift_w;
                    value_r <= value_r << 1;
                    cnt_r   <= cnt_r + 4'd1;
                    if (last) begin
                        out_bcd <= shift_w;
                        out_ovf <= ovf_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
